// File: rtl/mii_tx.sv
// mii_tx: MII transmit serializer.
// Accepts frame bytes over a valid/ready handshake. Optionally prepends the
// Ethernet preamble and SFD. Drives each byte onto the 4-bit MII bus, low
// nibble first, and holds TX_EN low for the inter-frame gap between frames.
//
// Parameters
//   PREAMBLE_EN  1 = send 7x0x55 + 0xD5 ahead of each frame, 0 = payload only
//   IFG_BYTES    inter-frame gap in byte times (1..255), i.e. 2*IFG_BYTES clocks
//
// Ports
//   mii_clk   in   transmit clock, rising edge
//   reset     in   asynchronous, active-high
//   tx_valid  in   tx_data / tx_last valid
//   tx_data   in   [7:0] frame byte
//   tx_last   in   final byte of the frame
//   tx_ready  out  byte accepted at the next edge if tx_valid is high
//   busy      out  block is not idle (registered)
//   underrun  out  one-cycle pulse when the source starves mid-frame (registered)
//   mii_en    out  MII TX_EN (registered)
//   mii_d     out  [3:0] MII TXD (registered)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus quiet, waiting for a frame
// PREAMBLE | preamble nibbles 0..14 = 0x5, nibble 15 = SFD 0xD
// DATA     | byte on the wire: low nibble, then high nibble
// IFG      | bus quiet for 2*IFG_BYTES clocks, tx_valid ignored

module mii_tx #(
   parameter bit PREAMBLE_EN = 1'b1,
   parameter int IFG_BYTES   = 12
) (
   input  logic       mii_clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       busy,
   output logic       underrun,
   output logic       mii_en,
   output logic [3:0] mii_d
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2,
      IFG      = 2'd3
   } state_t;

   localparam logic [8:0] SFD_CNT = 9'd15;
   localparam logic [8:0] PRE_END = 9'd14;
   localparam logic [8:0] IFG_END = 9'(2 * IFG_BYTES - 1);

   state_t     state, state_n;
   logic [8:0] cnt, cnt_n;
   logic [3:0] hi_nib, hi_nib_n;
   logic       last_byte, last_byte_n;
   logic       hi_phase, hi_phase_n;
   logic       mii_en_n;
   logic [3:0] mii_d_n;
   logic       underrun_n;
   logic       xfer;
   logic       starve;

   // Ready is a pure decode of the registered state so it never depends on
   // tx_valid within the same cycle.
   always_comb begin
      tx_ready = 1'b0;
      case (state)
         IDLE:     tx_ready = ~PREAMBLE_EN;
         PREAMBLE: tx_ready = (cnt == SFD_CNT);
         DATA:     tx_ready = hi_phase & ~last_byte;
         default:  tx_ready = 1'b0;
      endcase
   end

   assign xfer   = tx_ready & tx_valid;
   // Starving the block in IDLE is just "no frame yet", not an underrun.
   assign starve = tx_ready & ~tx_valid & (state != IDLE);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      hi_nib_n    = hi_nib;
      last_byte_n = last_byte;
      hi_phase_n  = hi_phase;
      mii_en_n    = mii_en;
      mii_d_n     = mii_d;
      underrun_n  = 1'b0;

      if (xfer) begin
         // Accepted byte: low nibble goes straight out, high nibble is held.
         state_n     = DATA;
         cnt_n       = 9'd0;
         mii_en_n    = 1'b1;
         mii_d_n     = tx_data[3:0];
         hi_nib_n    = tx_data[7:4];
         last_byte_n = tx_last;
         hi_phase_n  = 1'b0;
      end else if (starve) begin
         // Abandon the frame; the source is expected to drain or abort.
         state_n     = IFG;
         cnt_n       = 9'd0;
         mii_en_n    = 1'b0;
         mii_d_n     = 4'h0;
         hi_phase_n  = 1'b0;
         last_byte_n = 1'b0;
         underrun_n  = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               mii_en_n = 1'b0;
               mii_d_n  = 4'h0;
               if (PREAMBLE_EN && tx_valid) begin
                  state_n  = PREAMBLE;
                  cnt_n    = 9'd0;
                  mii_en_n = 1'b1;
                  mii_d_n  = 4'h5;
               end
            end
            PREAMBLE: begin
               // cnt==15 is always handled by xfer/starve above.
               cnt_n   = cnt + 9'd1;
               mii_d_n = (cnt == PRE_END) ? 4'hD : 4'h5;
            end
            DATA: begin
               if (!hi_phase) begin
                  mii_d_n    = hi_nib;
                  hi_phase_n = 1'b1;
               end else begin
                  // High nibble of the last byte has been sent.
                  state_n     = IFG;
                  cnt_n       = 9'd0;
                  mii_en_n    = 1'b0;
                  mii_d_n     = 4'h0;
                  hi_phase_n  = 1'b0;
                  last_byte_n = 1'b0;
               end
            end
            IFG: begin
               mii_en_n = 1'b0;
               mii_d_n  = 4'h0;
               if (cnt == IFG_END) begin
                  state_n = IDLE;
                  cnt_n   = 9'd0;
               end else begin
                  cnt_n = cnt + 9'd1;
               end
            end
            default: begin
               state_n  = IDLE;
               mii_en_n = 1'b0;
               mii_d_n  = 4'h0;
            end
         endcase
      end
   end

   always_ff @(posedge mii_clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 9'd0;
         hi_nib    <= 4'h0;
         last_byte <= 1'b0;
         hi_phase  <= 1'b0;
         mii_en    <= 1'b0;
         mii_d     <= 4'h0;
         underrun  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         hi_nib    <= hi_nib_n;
         last_byte <= last_byte_n;
         hi_phase  <= hi_phase_n;
         mii_en    <= mii_en_n;
         mii_d     <= mii_d_n;
         underrun  <= underrun_n;
         busy      <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_mii_tx.sv
// tb_mii_tx: randomized bench for mii_tx with a frame-level reference model.
// Two instances: u_a (preamble on, 12-byte gap) and u_b (payload only,
// 1-byte gap). sel picks which instance the driver and monitor talk to.

module tb_mii_tx;

   localparam int IFG_A   = 12;
   localparam int IFG_B   = 1;
   localparam int CYC_MAX = 4000;

   logic       mii_clk = 1'b0;
   logic       clk_en  = 1'b0;
   logic       reset;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_last;

   logic       ready_a, busy_a, und_a, en_a;
   logic [3:0] d_a;
   logic       ready_b, busy_b, und_b, en_b;
   logic [3:0] d_b;

   logic       sel = 1'b0;
   logic       ready_m, busy_m, und_m, en_m;
   logic [3:0] d_m;

   assign ready_m = sel ? ready_b : ready_a;
   assign busy_m  = sel ? busy_b  : busy_a;
   assign und_m   = sel ? und_b   : und_a;
   assign en_m    = sel ? en_b    : en_a;
   assign d_m     = sel ? d_b     : d_a;

   mii_tx #(.PREAMBLE_EN(1'b1), .IFG_BYTES(IFG_A)) u_a (
      .mii_clk (mii_clk),
      .reset   (reset),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .tx_last (tx_last),
      .tx_ready(ready_a),
      .busy    (busy_a),
      .underrun(und_a),
      .mii_en  (en_a),
      .mii_d   (d_a)
   );

   mii_tx #(.PREAMBLE_EN(1'b0), .IFG_BYTES(IFG_B)) u_b (
      .mii_clk (mii_clk),
      .reset   (reset),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .tx_last (tx_last),
      .tx_ready(ready_b),
      .busy    (busy_b),
      .underrun(und_b),
      .mii_en  (en_b),
      .mii_d   (d_b)
   );

   initial forever #5 if (clk_en) mii_clk = ~mii_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- stimulus and reference model ----------------
   logic [7:0] stim_data[$];
   bit         stim_last[$];
   bit         stim_drop[$];
   logic [7:0] fb[16];

   logic [3:0] exp_nib[$];
   int         exp_len[$];
   int         exp_und;

   // Frame of n bytes from fb[]; drop_after >= 0 means the source stops
   // after that byte, so the wire carries only bytes 0..drop_after.
   task automatic add_frame(input bit pe, input int n, input int drop_after);
      int sent;
      int len;
      sent = (drop_after >= 0) ? drop_after + 1 : n;
      len  = 0;
      if (pe) begin
         for (int i = 0; i < 15; i++) exp_nib.push_back(4'h5);
         exp_nib.push_back(4'hD);
         len = 16;
      end
      for (int i = 0; i < sent; i++) begin
         stim_data.push_back(fb[i]);
         stim_last.push_back(i == n - 1);
         stim_drop.push_back(i == drop_after);
         exp_nib.push_back(fb[i][3:0]);
         exp_nib.push_back(fb[i][7:4]);
      end
      exp_len.push_back(len + 2 * sent);
      if (drop_after >= 0) exp_und++;
   endtask

   // ---------------- monitor ----------------
   bit         mon_on = 1'b0;
   logic [3:0] obs_nib[$];
   int         obs_len[$];
   int         obs_gap[$];
   int         obs_ifg[$];
   int         cur_len, run_low, und_pulses, und_bad, out_bad;
   bit         seen_burst, prev_en, prev_busy, prev_und;

   always @(negedge mii_clk) begin
      if (mon_on) begin
         if (en_m) begin
            if (cur_len == 0 && seen_burst) obs_gap.push_back(run_low);
            obs_nib.push_back(d_m);
            cur_len++;
            run_low = 0;
            if (!busy_m) out_bad++;
         end else begin
            if (cur_len > 0) begin
               obs_len.push_back(cur_len);
               cur_len    = 0;
               seen_burst = 1'b1;
            end
            run_low++;
            if (d_m != 4'h0) out_bad++;
         end
         if (prev_busy && !busy_m) obs_ifg.push_back(run_low - 1);
         if (und_m) begin
            und_pulses++;
            if (!prev_en || en_m || prev_und) und_bad++;
         end
         prev_en   = en_m;
         prev_busy = busy_m;
         prev_und  = und_m;
      end
   end

   task automatic clear_all();
      stim_data.delete(); stim_last.delete(); stim_drop.delete();
      exp_nib.delete(); exp_len.delete(); exp_und = 0;
      obs_nib.delete(); obs_len.delete(); obs_gap.delete(); obs_ifg.delete();
      cur_len = 0; run_low = 0; und_pulses = 0; und_bad = 0; out_bad = 0;
      seen_burst = 1'b0; prev_en = 1'b0; prev_und = 1'b0; prev_busy = busy_m;
   endtask

   // ---------------- driver ----------------
   task automatic run_stream(output bit timed_out);
      int idx;
      int cyc;
      bit rdy;
      idx = 0;
      cyc = 0;
      timed_out = 1'b0;
      while (idx < stim_data.size() && !timed_out) begin
         tx_valid = 1'b1;
         tx_data  = stim_data[idx];
         tx_last  = stim_last[idx];
         @(negedge mii_clk); rdy = ready_m;
         @(posedge mii_clk); #1; cyc++;
         if (rdy) begin
            if (stim_drop[idx]) begin
               // Starve the block until it has seen a ready with no valid.
               tx_valid = 1'b0;
               tx_data  = 8'($urandom);
               tx_last  = 1'b1;
               do begin
                  @(negedge mii_clk); rdy = ready_m;
                  @(posedge mii_clk); #1; cyc++;
               end while (!rdy && cyc < CYC_MAX);
            end
            idx++;
         end
         if (cyc >= CYC_MAX) timed_out = 1'b1;
      end
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      cyc = 0;
      while (busy_m && cyc < CYC_MAX) begin
         @(posedge mii_clk); #1; cyc++;
      end
      if (cyc >= CYC_MAX) timed_out = 1'b1;
      repeat (4) @(posedge mii_clk);
      #1;
   endtask

   task automatic run_case(input string name, input int ifg);
      bit to;
      mon_on = 1'b1;
      run_stream(to);
      mon_on = 1'b0;
      check({name, "_timeout"}, 32'(to), 0);
      check({name, "_bursts"}, obs_len.size(), exp_len.size());
      for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++)
         check({name, "_burst_len"}, obs_len[i], exp_len[i]);
      check({name, "_nibbles"}, obs_nib.size(), exp_nib.size());
      for (int i = 0; i < exp_nib.size() && i < obs_nib.size(); i++)
         check({name, "_nib"}, obs_nib[i], exp_nib[i]);
      check({name, "_gaps"}, obs_gap.size(), (exp_len.size() > 0) ? exp_len.size() - 1 : 0);
      for (int i = 0; i < obs_gap.size(); i++)
         check({name, "_gap_len"}, obs_gap[i], 2 * ifg + 1);
      check({name, "_busy_falls"}, obs_ifg.size(), exp_len.size());
      for (int i = 0; i < obs_ifg.size(); i++)
         check({name, "_ifg_len"}, obs_ifg[i], 2 * ifg);
      check({name, "_underruns"}, und_pulses, exp_und);
      check({name, "_underrun_shape"}, und_bad, 0);
      check({name, "_idle_outputs"}, out_bad, 0);
   endtask

   task automatic random_frames(input bit pe, input int ifg, input string name);
      int nf;
      int n;
      int drop;
      clear_all();
      nf = $urandom_range(2, 4);
      for (int f = 0; f < nf; f++) begin
         n = $urandom_range(1, 6);
         for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
         drop = -1;
         if (n >= 2 && $urandom_range(0, 3) == 0) drop = $urandom_range(0, n - 2);
         add_frame(pe, n, drop);
      end
      run_case(name, ifg);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tx_last  = 1'b0;
      exp_und  = 0;
      #3;
      check("rst_ready_a", ready_a, 0);
      check("rst_busy_a",  busy_a,  0);
      check("rst_und_a",   und_a,   0);
      check("rst_en_a",    en_a,    0);
      check("rst_d_a",     d_a,     0);
      check("rst_ready_b", ready_b, 1);
      check("rst_en_b",    en_b,    0);
      clk_en = 1'b1;
      @(posedge mii_clk); #1;
      reset = 1'b0;
      repeat (10) @(posedge mii_clk);
      @(negedge mii_clk);
      check("idle_ready_a", ready_a, 0);
      check("idle_busy_a",  busy_a,  0);
      check("idle_en_a",    en_a,    0);
      check("idle_d_a",     d_a,     0);
      check("idle_und_a",   und_a,   0);
      check("idle_ready_b", ready_b, 1);
      @(posedge mii_clk); #1;

      sel = 1'b0;
      clear_all();
      fb[0] = 8'hA7;
      add_frame(1'b1, 1, -1);
      run_case("single_a7", IFG_A);

      clear_all();
      fb[0] = 8'h01; fb[1] = 8'h02;
      add_frame(1'b1, 2, -1);
      fb[0] = 8'h03; fb[1] = 8'h04;
      add_frame(1'b1, 2, -1);
      run_case("back_to_back", IFG_A);

      clear_all();
      fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33;
      add_frame(1'b1, 3, 0);
      run_case("underrun", IFG_A);

      for (int r = 0; r < 5; r++) random_frames(1'b1, IFG_A, "rand_pre");

      sel = 1'b1;
      @(posedge mii_clk); #1;
      clear_all();
      fb[0] = 8'h3C; fb[1] = 8'h5A;
      add_frame(1'b0, 2, -1);
      run_case("nopre_3c5a", IFG_B);

      for (int r = 0; r < 5; r++) random_frames(1'b0, IFG_B, "rand_nopre");

      // Asynchronous reset in the middle of a payload byte.
      sel = 1'b0;
      @(posedge mii_clk); #1;
      tx_valid = 1'b1;
      tx_data  = 8'h96;
      tx_last  = 1'b0;
      repeat (20) @(posedge mii_clk);
      #2;
      check("pre_reset_en", en_a, 1);
      check("pre_reset_busy", busy_a, 1);
      reset = 1'b1;
      #1;
      check("async_reset_en", en_a, 0);
      check("async_reset_busy", busy_a, 0);
      tx_valid = 1'b0;
      @(posedge mii_clk); #1;
      reset = 1'b0;
      @(posedge mii_clk); #1;
      clear_all();
      fb[0] = 8'h5E; fb[1] = 8'hC1;
      add_frame(1'b1, 2, -1);
      run_case("after_reset", IFG_A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mii_tx.md
# mii_tx

MII transmit serializer: the transmit-side counterpart of the MII nibble receiver. It accepts frame bytes from an upstream source through a valid/ready handshake. It prepends the Ethernet preamble and SFD, drives each byte onto the 4-bit MII bus low nibble first, and enforces the inter-frame gap. It sits between the frame source (packet generator or loopback buffer) and the PHY's TXD/TX_EN pins.

## Interface
- PREAMBLE_EN, 1, 1 = insert 7×0x55 + 0xD5 before each frame; 0 = send payload bytes only
- IFG_BYTES, 12, inter-frame gap in byte times (legal 1..255); gap is 2×IFG_BYTES clocks
- mii_clk  in  1  transmit clock; every register samples on its rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- tx_valid  in  1  tx_data/tx_last valid; the source holds it high from frame start through the last byte
- tx_data  in  8  frame byte
- tx_last  in  1  marks the final byte of the frame
- tx_ready  out  1  block accepts tx_data this cycle; a transfer occurs when tx_valid && tx_ready at the edge
- busy  out  1  high in any state except IDLE
- underrun  out  1  one-cycle pulse when the source fails to supply a byte mid-frame
- mii_en  out  1  MII TX_EN
- mii_d  out  4  MII TXD[3:0]

## Operation
- Reset (async, immediate): state=IDLE, mii_en=0, mii_d=0, tx_ready=0 (1 if PREAMBLE_EN=0), busy=0, underrun=0, counters and byte register cleared. A frame interrupted by reset is discarded and not resumed.
- mii_en, mii_d, underrun and busy are registered. tx_ready is decoded from state only and does not depend combinationally on tx_valid.
- States: IDLE, PREAMBLE, DATA, IFG.
- IDLE:
  - PREAMBLE_EN=1: tx_ready=0. When tx_valid=1 at an edge, go to PREAMBLE with the nibble counter at 0.
  - PREAMBLE_EN=0: tx_ready=1. A transfer at an edge goes to DATA and outputs the low nibble.
- PREAMBLE: 16 nibbles with mii_en=1 — 15×0x5, then 0xD.
  - tx_ready=1 only while 0xD is on the wire.
  - A transfer at that edge loads the byte and enters DATA.
- DATA: each byte takes 2 cycles, tx_data[3:0] then tx_data[7:4]. The high nibble and the last flag are held internally.
  - tx_ready=1 during the high-nibble cycle unless the current byte had tx_last=1.
  - A transfer at that edge emits the next byte's low nibble with no gap.
  - If the current byte is last: at the end of its high nibble, mii_en=0 and mii_d=0, and the state goes to IFG.
- Underrun: tx_ready=1 but tx_valid=0 at the edge (in DATA or at the SFD nibble).
  - mii_en=0 and mii_d=0 at that edge, underrun=1 for exactly one cycle, state goes to IFG.
  - The source must drain or abort its frame; the block does not resynchronize mid-frame.
- IFG: mii_en=0 for exactly 2×IFG_BYTES cycles, then IDLE. tx_valid is ignored here.
- tx_last on a byte whose tx_valid is low has no effect.

## Timing
- PREAMBLE_EN=1, tx_valid sampled high in IDLE at edge N:
  - mii_en=1, mii_d=0x5 from edge N through N+14.
  - mii_d=0xD after N+15, with tx_ready high in that cycle.
  - First byte accepted at N+16; its low nibble is driven after N+16.
- PREAMBLE_EN=0: byte accepted at edge N; mii_en=1 with its low nibble after N.
- In DATA: byte accepted at edge K → low nibble after K, high nibble after K+1, next transfer at K+2.
- Sustained throughput: 1 byte per 2 clocks.
- Last byte accepted at K → mii_en falls at K+2. Minimum mii_en low time before the next frame is 2×IFG_BYTES+1 clocks (25 at default), the extra clock being the IDLE sample.
- Frame length is unbounded; counters wrap only within the preamble (0..15) and the IFG (0..2×IFG_BYTES−1).
- Simultaneous events:
  - tx_valid arriving during IFG is held off until IDLE.
  - Reset asserted during any state overrides everything asynchronously.

## Test plan
- Reset: assert reset with no clock → all outputs 0 (tx_ready=0 for PREAMBLE_EN=1); deassert and idle 10 clocks → outputs unchanged.
- Single-byte frame 0xA7 with last, PREAMBLE_EN=1:
  - mii_en high exactly 18 cycles, carrying 5×15, D, 7, A.
  - Then 24 low cycles and busy falls; underrun stays 0.
- Back-to-back frames {0x01,0x02} and {0x03,0x04}, tx_valid held high:
  - Data nibbles 1,0,2,0 then 3,0,4,0.
  - Exactly 25 clocks of mii_en=0 between frames.
- Underrun: 3-byte frame 0x11,0x22,0x33 with tx_valid dropped after 0x11 → mii_d 1,1, then mii_en=0 at the next edge, underrun pulses 1 cycle, 24 IFG cycles follow.
- PREAMBLE_EN=0, IFG_BYTES=1, frame 0x3C,0x5A:
  - mii_en rises the cycle after the accept, carrying C,3,A,5.
  - Gap is 3 clocks.
- Async reset mid-DATA → mii_en and busy drop without a clock edge. The next frame starts with the full 16-nibble preamble.
